// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access controller: funct3/size codes,
// FSM states, byte-enable constants and the misalignment rule.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Unknown funct3/size codes behave as full-word accesses.
  function automatic logic is_misaligned(input logic       i_is_load,
                                         input logic [2:0] i_f3,
                                         input logic [1:0] i_size,
                                         input logic [1:0] i_addr_lo);
    logic r_mis;
    r_mis = 1'b0;
    if (i_is_load) begin
      case (i_f3)
        F3_LB, F3_LBU: r_mis = 1'b0;
        F3_LH, F3_LHU: r_mis = i_addr_lo[0];
        default:       r_mis = (i_addr_lo != 2'b00);
      endcase
    end else begin
      case (i_size)
        ST_SB:   r_mis = 1'b0;
        ST_SH:   r_mis = i_addr_lo[0];
        default: r_mis = (i_addr_lo != 2'b00);
      endcase
    end
    return r_mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the access controller and memory.
interface mem_access_unit_if;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN,
    input  DMEM_RDATA, DMEM_ACK
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN,
    output DMEM_RDATA, DMEM_ACK
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: store byte replication/strobes and load
// byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_addr_lo,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_byte_en,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [2:0]  i_ld_f3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata   = i_st_data;
    o_byte_en = BE_WORD;
    case (i_st_size)
      ST_SB: begin
        o_wdata   = {4{i_st_data[7:0]}};
        o_byte_en = BE_BYTE << i_st_addr_lo;
      end
      ST_SH: begin
        o_wdata   = {2{i_st_data[15:0]}};
        o_byte_en = BE_HALF << {i_st_addr_lo[1], 1'b0};
      end
      default: begin
        o_wdata   = i_st_data;
        o_byte_en = BE_WORD;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_ld_data = i_rdata;
    case (i_ld_f3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_ld_data = {24'd0, w_byte};
      F3_LHU:  o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: IDLE/ACCESS/DONE handshake with data memory,
// pipeline stall generation and registered load result. Option: MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        MEM_ALU_OUT,
  input  logic [31:0]        MEM_REG_DATA2,
  input  logic [3:0]         MEM_DATA_MEM_READ,
  input  logic [2:0]         MEM_DATA_MEM_WRITE,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        MEM_READ_DATA,
  output logic               MEM_BUSY,
  output logic               MEM_FAULT
);

  state_t      r_state;
  state_t      w_next;
  logic        w_ld_en;
  logic        w_st_en;
  logic        w_any_en;
  logic        w_misalign;
  logic        w_latch;
  logic        w_capture;
  logic [31:0] w_wdata;
  logic [3:0]  w_byte_en;
  logic [31:0] w_ld_data;

  logic [31:0] r_addr;
  logic [1:0]  r_addr_lo;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_byte_en;
  logic [2:0]  r_ld_f3;
  logic [31:0] r_rd_data;

  assign w_ld_en  = MEM_DATA_MEM_READ[3];
  assign w_st_en  = MEM_DATA_MEM_WRITE[2];
  assign w_any_en = w_ld_en | w_st_en;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign = is_misaligned(w_ld_en, MEM_DATA_MEM_READ[2:0],
                                    MEM_DATA_MEM_WRITE[1:0], MEM_ALU_OUT[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .i_st_addr_lo (MEM_ALU_OUT[1:0]),
    .i_st_size    (MEM_DATA_MEM_WRITE[1:0]),
    .i_st_data    (MEM_REG_DATA2),
    .o_wdata      (w_wdata),
    .o_byte_en    (w_byte_en),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_f3      (r_ld_f3),
    .i_rdata      (dmem.DMEM_RDATA),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Acks outside ACCESS are ignored because only the ACCESS arm looks at them.
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_en) begin
          w_latch = 1'b1;
          w_next  = w_misalign ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (dmem.DMEM_ACK) begin
          w_next    = S_DONE;
          w_capture = ~r_we;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Load wins over store when both enables are set, so WE is simply !load.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr    <= 32'd0;
      r_addr_lo <= 2'd0;
      r_we      <= 1'b0;
      r_wdata   <= 32'd0;
      r_byte_en <= 4'd0;
      r_ld_f3   <= 3'd0;
      r_rd_data <= 32'd0;
    end else begin
      if (w_latch) begin
        r_addr    <= {MEM_ALU_OUT[31:2], 2'b00};
        r_addr_lo <= MEM_ALU_OUT[1:0];
        r_we      <= ~w_ld_en;
        r_wdata   <= w_wdata;
        r_byte_en <= w_byte_en;
        r_ld_f3   <= MEM_DATA_MEM_READ[2:0];
      end
      if (w_capture) r_rd_data <= w_ld_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        r_misalign <= 1'b0;
    else if (w_latch) r_misalign <= w_misalign;
  end
  assign MEM_FAULT = (r_state == S_DONE) & r_misalign;
`else
  assign MEM_FAULT = 1'b0;
`endif

  assign dmem.DMEM_REQ     = (r_state == S_ACCESS);
  assign dmem.DMEM_WE      = r_we;
  assign dmem.DMEM_ADDR    = r_addr;
  assign dmem.DMEM_WDATA   = r_wdata;
  assign dmem.DMEM_BYTE_EN = r_byte_en;
  assign MEM_READ_DATA     = r_rd_data;
  assign MEM_BUSY          = ((r_state == S_IDLE) & w_any_en) | (r_state == S_ACCESS);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a byte-level reference
// model of lane placement, extraction and handshake timing.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] reg_data2 = 32'd0;
  logic [3:0]  rd_ctl = 4'd0;
  logic [2:0]  wr_ctl = 3'd0;
  logic [31:0] read_data;
  logic        busy;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rd = 32'd0;

  mem_access_unit_if dmem ();

  mem_access_unit dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .MEM_ALU_OUT        (alu_out),
    .MEM_REG_DATA2      (reg_data2),
    .MEM_DATA_MEM_READ  (rd_ctl),
    .MEM_DATA_MEM_WRITE (wr_ctl),
    .dmem               (dmem.master),
    .MEM_READ_DATA      (read_data),
    .MEM_BUSY           (busy),
    .MEM_FAULT          (fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, naturally aligned lane offset.
  function automatic int nb_ld(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int nb_st(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    off = ((addr % 4) / n) * n;
    be = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n;
    int off;
    logic [31:0] v;
    n = nb_ld(f3);
    if (n == 4) return rdata;
    off = ((addr % 4) / n) * n;
    v = rdata >> (8 * off);
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic st, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int waitc);
    int n;
    int busy_cnt;
    logic mis;
    n = ld ? nb_ld(f3) : nb_st(sz);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = ((addr % n) != 0);
`endif
    busy_cnt = 0;
    alu_out = addr; reg_data2 = sdata; rd_ctl = {ld, f3}; wr_ctl = {st, sz};
    #1;
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".idle_req"}, {31'd0, dmem.DMEM_REQ}, 32'd0);
    if (busy) busy_cnt++;
    @(posedge CLK); #1;
    if (mis) begin
      check({tag, ".mis_req"}, {31'd0, dmem.DMEM_REQ}, 32'd0);
      check({tag, ".mis_fault"}, {31'd0, fault}, 32'd1);
      check({tag, ".mis_busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".mis_rd"}, read_data, exp_rd);
    end else begin
      for (int w = 0; w <= waitc; w++) begin
        check({tag, ".req"}, {31'd0, dmem.DMEM_REQ}, 32'd1);
        check({tag, ".we"}, {31'd0, dmem.DMEM_WE}, {31'd0, ~ld});
        check({tag, ".addr"}, dmem.DMEM_ADDR, {addr[31:2], 2'b00});
        if (!ld) begin
          check({tag, ".be"}, {28'd0, dmem.DMEM_BYTE_EN}, {28'd0, model_be(n, addr)});
          check({tag, ".wdata"}, dmem.DMEM_WDATA, model_wdata(n, sdata));
        end
        if (busy) busy_cnt++;
        if (w == waitc) begin
          dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = rdata;
        end else begin
          dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = $urandom;
        end
        @(posedge CLK); #1;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = $urandom;
      end
      if (ld) exp_rd = model_load(f3, addr, rdata);
      check({tag, ".done_req"}, {31'd0, dmem.DMEM_REQ}, 32'd0);
      check({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".done_fault"}, {31'd0, fault}, 32'd0);
      check({tag, ".rd"}, read_data, exp_rd);
      check({tag, ".busy_cycles"}, busy_cnt, waitc + 2);
    end
    rd_ctl = 4'd0; wr_ctl = 3'd0;
    @(posedge CLK); #1;
    check({tag, ".back_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".back_idle_fault"}, {31'd0, fault}, 32'd0);
    check({tag, ".back_idle_rd"}, read_data, exp_rd);
  endtask

  initial begin
    dmem.DMEM_ACK = 1'b0;
    dmem.DMEM_RDATA = 32'd0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst.req", {31'd0, dmem.DMEM_REQ}, 32'd0);
    check("rst.we", {31'd0, dmem.DMEM_WE}, 32'd0);
    check("rst.addr", dmem.DMEM_ADDR, 32'd0);
    check("rst.wdata", dmem.DMEM_WDATA, 32'd0);
    check("rst.be", {28'd0, dmem.DMEM_BYTE_EN}, 32'd0);
    check("rst.rd", read_data, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.fault", {31'd0, fault}, 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Spurious ack in IDLE
    dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = 32'hDEADBEEF;
    @(posedge CLK); #1;
    dmem.DMEM_ACK = 1'b0;
    check("spur.rd", read_data, 32'd0);
    check("spur.req", {31'd0, dmem.DMEM_REQ}, 32'd0);
    check("spur.busy", {31'd0, busy}, 32'd0);

    // Directed cases
    run_op("sb_103", 1'b0, 3'b000, 1'b1, 2'b00, 32'h0000_0103, 32'h0000_00AB, 32'h0, 2);
    check("sb_103.be_lit", {28'd0, dmem.DMEM_BYTE_EN}, 32'h8);
    check("sb_103.wd_lit", dmem.DMEM_WDATA, 32'hABAB_ABAB);
    run_op("lb_201", 1'b1, 3'b000, 1'b0, 2'b00, 32'h0000_0201, 32'h0, 32'h1234_8056, 1);
    check("lb_201.lit", read_data, 32'hFFFF_FF80);
    run_op("lbu_201", 1'b1, 3'b100, 1'b0, 2'b00, 32'h0000_0201, 32'h0, 32'h1234_8056, 0);
    check("lbu_201.lit", read_data, 32'h0000_0080);
    run_op("lhu_202", 1'b1, 3'b101, 1'b0, 2'b00, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 1);
    check("lhu_202.lit", read_data, 32'h0000_BEEF);
    run_op("lw_0w", 1'b1, 3'b010, 1'b0, 2'b00, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0);
    run_op("sh_206", 1'b0, 3'b000, 1'b1, 2'b01, 32'h0000_0206, 32'h0000_9A5C, 32'h0, 1);
    run_op("sw_208", 1'b0, 3'b000, 1'b1, 2'b10, 32'h0000_0208, 32'h1357_9BDF, 32'h0, 0);
    run_op("ld_st_both", 1'b1, 3'b001, 1'b1, 2'b10, 32'h0000_0512, 32'h1111_2222, 32'h8001_7FFF, 1);
    run_op("lw_301", 1'b1, 3'b010, 1'b0, 2'b00, 32'h0000_0301, 32'h0, 32'h0BAD_CAFE, 1);
    run_op("sh_odd", 1'b0, 3'b000, 1'b1, 2'b01, 32'h0000_0603, 32'h0000_55AA, 32'h0, 0);

    // Reset while ACCESS waits for ack
    alu_out = 32'h0000_0700; rd_ctl = 4'b1010; wr_ctl = 3'd0;
    @(posedge CLK); #1;
    check("rstacc.req_before", {31'd0, dmem.DMEM_REQ}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1; rd_ctl = 4'd0;
    #1;
    exp_rd = 32'd0;
    check("rstacc.req", {31'd0, dmem.DMEM_REQ}, 32'd0);
    check("rstacc.busy", {31'd0, busy}, 32'd0);
    check("rstacc.rd", read_data, exp_rd);
    @(posedge CLK); #1;
    RESET = 1'b0;
    dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = 32'h7777_7777;
    @(posedge CLK); #1;
    dmem.DMEM_ACK = 1'b0;
    check("rstacc.late_ack_rd", read_data, exp_rd);
    check("rstacc.late_ack_req", {31'd0, dmem.DMEM_REQ}, 32'd0);

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      logic ld, st;
      logic [2:0] f3;
      logic [1:0] sz;
      int sel;
      sel = $urandom_range(0, 2);
      ld = (sel != 1);
      st = (sel != 0);
      f3 = 3'($urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      run_op("rand", ld, f3, st, sz, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
